// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC fetch front end.
// Holds the fetch FSM encoding, PC width, reset address and the PC incrementer.
package wisc_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Unsigned modular increment; FFFF wraps to 0000.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter and fetch sequencer: holds fetch while a control
// transfer resolves, handles load-use stalls, HLT, and a resolve watchdog.
module pc_fetch_ctrl
  import wisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            ctrl_xfer_id,
  input  logic            halt_id,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] PC_update,
  input  logic            PC_src,
  input  logic            update_done,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic            fetch_valid,
  output logic            waiting,
  output logic            halted,
  output logic            err_resolve
);

  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_valid;
  logic [7:0]      r_wait_cnt;
  logic            r_err;

  fetch_state_t    w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic            w_fetch_valid_next;
  logic [7:0]      w_wait_cnt_next;
  logic            w_err_next;
  logic [7:0]      w_wait_cnt_inc;

  assign w_wait_cnt_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_wait_cnt    <= 8'd0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_err         <= w_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_fetch_valid_next = r_fetch_valid;
    w_wait_cnt_next    = r_wait_cnt;
    w_err_next         = r_err;
    case (r_state)
      RUN: begin
        // A stall freezes everything; halt/xfer are re-sampled once it drops.
        if (!stall_in) begin
          if (halt_id) begin
            w_state_next       = HALTED;
            w_fetch_valid_next = 1'b0;
          end else if (ctrl_xfer_id) begin
            w_state_next       = WAIT;
            w_fetch_valid_next = 1'b0;
            w_wait_cnt_next    = 8'd0;
          end else begin
            w_pc_next          = pc_inc(r_pc);
            w_fetch_valid_next = 1'b1;
          end
        end
      end
      WAIT: begin
        w_fetch_valid_next = 1'b0;
        if (resolve_valid) begin
          w_state_next       = RUN;
          w_fetch_valid_next = 1'b1;
          if (PC_src) begin
            w_pc_next = PC_update;
          end
          if (update_done != PC_src) begin
            w_err_next = 1'b1;
          end
        end else begin
          w_wait_cnt_next = w_wait_cnt_inc;
          // Watchdog: resume at the held PC rather than deadlock.
          if (w_wait_cnt_inc >= C_MAX_WAIT) begin
            w_err_next         = 1'b1;
            w_state_next       = RUN;
            w_fetch_valid_next = 1'b1;
          end
        end
      end
      HALTED: begin
        w_fetch_valid_next = 1'b0;
      end
      default: begin
        w_state_next       = RUN;
        w_fetch_valid_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_out      = r_pc;
    pc_plus1    = pc_inc(r_pc);
    fetch_valid = r_fetch_valid;
    waiting     = (r_state == WAIT);
    halted      = (r_state == HALTED);
    err_resolve = r_err;
  end

endmodule
